// File: rtl/dphy_clkdiv_gen.sv
// Multi-channel programmable clock divider with per-period trigger pulses,
// glitch-free ratio updates via valid/ready and a global phase-align request.
module dphy_clkdiv_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              ext_rstb,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] clk_div_out,
    output logic [NUM_CH-1:0] trig_out,
    output logic [NUM_CH-1:0] ch_running
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ch_state_t;

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_TWO  = DIV_W'(2);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

    ch_state_t        state_q    [NUM_CH];
    ch_state_t        state_d    [NUM_CH];
    logic [DIV_W-1:0] cnt_q      [NUM_CH];
    logic [DIV_W-1:0] cnt_d      [NUM_CH];
    logic [DIV_W-1:0] active_q   [NUM_CH];
    logic [DIV_W-1:0] active_d   [NUM_CH];
    logic [DIV_W-1:0] pend_div_q [NUM_CH];
    logic [DIV_W-1:0] pend_div_d [NUM_CH];
    logic [DIV_W-1:0] eff_div    [NUM_CH];
    logic [NUM_CH-1:0] pend_flag_q, pend_flag_d;
    logic [NUM_CH-1:0] wrap, do_sync, apply, div_ok;
    logic [NUM_CH-1:0] clk_d, trig_d, run_d;
    logic              cfg_in_range, cfg_take;

    always_comb begin
        cfg_in_range = {1'b0, cfg_ch} < CH_LIMIT;
        cfg_ready    = cfg_in_range ? !pend_flag_q[cfg_ch] : 1'b1;
        cfg_take     = cfg_valid && cfg_ready && cfg_in_range;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            active_d[i]    = active_q[i];
            pend_div_d[i]  = pend_div_q[i];
            pend_flag_d[i] = pend_flag_q[i];
            wrap[i]    = (state_q[i] != IDLE) && (cnt_q[i] == active_q[i] - DIV_ONE);
            do_sync[i] = sync_req && (state_q[i] == RUN);
            apply[i]   = pend_flag_q[i] && ((state_q[i] == IDLE) || wrap[i] || do_sync[i]);
            eff_div[i] = apply[i] ? pend_div_q[i] : active_q[i];
            div_ok[i]  = eff_div[i] >= DIV_TWO;

            if (apply[i]) begin
                active_d[i]    = pend_div_q[i];
                pend_flag_d[i] = 1'b0;
            end else if (cfg_take && (cfg_ch == CH_W'(i))) begin
                pend_div_d[i]  = cfg_div;
                pend_flag_d[i] = 1'b1;
            end

            // Period boundaries (wrap or sync) restart at 0, so a new ratio never leaves a runt.
            if (state_q[i] == IDLE) begin
                cnt_d[i]   = '0;
                state_d[i] = (ch_en[i] && div_ok[i]) ? RUN : IDLE;
            end else if (do_sync[i]) begin
                cnt_d[i]   = '0;
                state_d[i] = !div_ok[i] ? IDLE : (ch_en[i] ? RUN : DRAIN);
            end else if (wrap[i]) begin
                cnt_d[i]   = '0;
                state_d[i] = (div_ok[i] && ch_en[i]) ? RUN : IDLE;
            end else begin
                cnt_d[i]   = cnt_q[i] + DIV_ONE;
                state_d[i] = ch_en[i] ? RUN : DRAIN;
            end

            run_d[i]  = state_d[i] != IDLE;
            clk_d[i]  = run_d[i] && (cnt_d[i] < (active_d[i] >> 1));
            trig_d[i] = run_d[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge ext_rstb) begin
        if (!ext_rstb) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= IDLE;
                cnt_q[i]      <= '0;
                active_q[i]   <= DIV_RST;
                pend_div_q[i] <= '0;
            end
            pend_flag_q <= '0;
            clk_div_out <= '0;
            trig_out    <= '0;
            ch_running  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= state_d[i];
                cnt_q[i]      <= cnt_d[i];
                active_q[i]   <= active_d[i];
                pend_div_q[i] <= pend_div_d[i];
            end
            pend_flag_q <= pend_flag_d;
            clk_div_out <= clk_d;
            trig_out    <= trig_d;
            ch_running  <= run_d;
        end
    end

endmodule

// File: tb/tb_dphy_clkdiv_gen.sv
// Bench for dphy_clkdiv_gen: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a period-position model.
module tb_dphy_clkdiv_gen;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int DEF    = 2;
    localparam int CH_W   = 1;

    logic              clk = 1'b0;
    logic              ext_rstb = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              cfg_valid = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cfg_ready;
    logic              sync_req = 1'b0;
    logic [NUM_CH-1:0] clk_div_out, trig_out, ch_running;

    int total = 0;
    int bad   = 0;

    dphy_clkdiv_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .ext_rstb(ext_rstb), .ch_en(ch_en), .cfg_valid(cfg_valid),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ready(cfg_ready), .sync_req(sync_req),
        .clk_div_out(clk_div_out), .trig_out(trig_out), .ch_running(ch_running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
    endtask

    // Model: pos = position within the current period (-1 when stopped),
    // stopping = enable has been withdrawn and the period is being finished.
    int m_act  [NUM_CH];
    int m_pend [NUM_CH];
    int m_pos  [NUM_CH];
    bit m_stop [NUM_CH];
    bit m_rdy  [NUM_CH];
    bit m_s, m_last;

    always @(posedge clk or negedge ext_rstb) begin
        if (!ext_rstb) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_act[i] = DEF; m_pend[i] = -1; m_pos[i] = -1; m_stop[i] = 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) m_rdy[i] = (m_pend[i] < 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_pos[i] < 0) begin
                    if (m_pend[i] >= 0) begin m_act[i] = m_pend[i]; m_pend[i] = -1; end
                    if (ch_en[i] && m_act[i] >= 2) begin m_pos[i] = 0; m_stop[i] = 0; end
                end else begin
                    m_s    = sync_req && !m_stop[i];
                    m_last = (m_pos[i] == m_act[i] - 1);
                    if (m_s || m_last) begin
                        if (m_pend[i] >= 0) begin m_act[i] = m_pend[i]; m_pend[i] = -1; end
                        if (m_act[i] < 2) m_pos[i] = -1;
                        else if (m_s) begin m_pos[i] = 0; m_stop[i] = !ch_en[i]; end
                        else if (ch_en[i]) begin m_pos[i] = 0; m_stop[i] = 0; end
                        else m_pos[i] = -1;
                    end else begin
                        m_pos[i]++;
                        m_stop[i] = !ch_en[i];
                    end
                end
            end
            if (cfg_valid && int'(cfg_ch) < NUM_CH && m_rdy[cfg_ch]) m_pend[cfg_ch] = int'(cfg_div);
        end
    end

    logic [NUM_CH-1:0] e_clk, e_trig, e_run;
    bit e_rdy;

    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            e_run[i]  = m_pos[i] >= 0;
            e_clk[i]  = m_pos[i] >= 0 && m_pos[i] < m_act[i] / 2;
            e_trig[i] = m_pos[i] == 0;
        end
        e_rdy = (int'(cfg_ch) >= NUM_CH) || (m_pend[cfg_ch] < 0);
        chk("model_clk_div_out", int'(clk_div_out), int'(e_clk));
        chk("model_trig_out", int'(trig_out), int'(e_trig));
        chk("model_ch_running", int'(ch_running), int'(e_run));
        chk("model_cfg_ready", int'(cfg_ready), int'(e_rdy));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int ch, input int div);
        int n;
        cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(div);
        #1;
        n = 0;
        while (!cfg_ready && n < 300) begin tick(); #1; n++; end
        if (n >= 300) timeout("cfg_accept");
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_trig0();
        int n;
        n = 0;
        do begin tick(); n++; end while (!trig_out[0] && n < 300);
        if (!trig_out[0]) timeout("wait_trig0");
    endtask

    int cfg_clk  [11] = '{1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1};
    int cfg_trig [11] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    int cfg_rdy  [11] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1};

    initial begin
        int n, r;
        repeat (3) tick();
        chk("reset_clk", int'(clk_div_out), 0);
        chk("reset_trig", int'(trig_out), 0);
        chk("reset_running", int'(ch_running), 0);
        chk("reset_ready", int'(cfg_ready), 1);
        ext_rstb = 1'b1;
        tick();
        ch_en = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("div2_clk0", int'(clk_div_out[0]), (k % 2 == 0) ? 1 : 0);
            chk("div2_trig0", int'(trig_out[0]), (k % 2 == 0) ? 1 : 0);
            chk("div2_ch1_idle", int'(clk_div_out[1]), 0);
        end

        // Ratio 5 issued at the last cycle of a period, then a stalled ratio 3.
        cfg_valid = 1'b1; cfg_ch = '0; cfg_div = 8'd5;
        #1;
        chk("cfg_ready_idle", int'(cfg_ready), 1);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("cfg_seq_clk0", int'(clk_div_out[0]), cfg_clk[k]);
            chk("cfg_seq_trig0", int'(trig_out[0]), cfg_trig[k]);
            chk("cfg_seq_ready", int'(cfg_ready), cfg_rdy[k]);
            if (k == 0) cfg_div = 8'd3;
            if (k == 3) cfg_valid = 1'b0;
        end

        do_cfg(0, 4);
        do_cfg(1, 6);
        ch_en = 2'b11;
        repeat (16) tick();
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        chk("sync_trig", int'(trig_out), 3);
        chk("sync_clk", int'(clk_div_out), 3);

        // Drain on ch0 (ratio 4): disable at cnt=1.
        wait_trig0();
        tick();
        ch_en[0] = 1'b0;
        tick();
        chk("drain_run_c2", int'(ch_running[0]), 1);
        chk("drain_clk_c2", int'(clk_div_out[0]), 0);
        tick();
        chk("drain_run_c3", int'(ch_running[0]), 1);
        tick();
        chk("drain_idle_run", int'(ch_running[0]), 0);
        chk("drain_idle_clk", int'(clk_div_out[0]), 0);
        chk("drain_idle_trig", int'(trig_out[0]), 0);
        ch_en[0] = 1'b1;
        tick();
        chk("reen_trig", int'(trig_out[0]), 1);
        tick();
        ch_en[0] = 1'b0;
        tick();
        ch_en[0] = 1'b1;
        chk("redrain_run", int'(ch_running[0]), 1);
        tick();
        chk("redrain_c3_clk", int'(clk_div_out[0]), 0);
        chk("redrain_c3_trig", int'(trig_out[0]), 0);
        tick();
        chk("nogap_trig", int'(trig_out[0]), 1);
        chk("nogap_clk", int'(clk_div_out[0]), 1);

        // Ratio 1 stops ch1 even with enable high; ratio 3 restarts it.
        do_cfg(1, 1);
        n = 0;
        while (ch_running[1] && n < 20) begin tick(); n++; end
        if (ch_running[1]) timeout("ratio1_stop");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ratio1_clk1", int'(clk_div_out[1]), 0);
            chk("ratio1_run1", int'(ch_running[1]), 0);
        end
        do_cfg(1, 3);
        tick();
        chk("ratio3_run1", int'(ch_running[1]), 1);
        chk("ratio3_trig1", int'(trig_out[1]), 1);

        // Asynchronous reset mid-period.
        repeat (2) tick();
        ext_rstb = 1'b0;
        #1;
        chk("async_rst_clk", int'(clk_div_out), 0);
        chk("async_rst_trig", int'(trig_out), 0);
        chk("async_rst_run", int'(ch_running), 0);
        chk("async_rst_ready", int'(cfg_ready), 1);
        repeat (2) tick();
        ext_rstb = 1'b1;
        ch_en = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_div2", int'(clk_div_out[0]), (k % 2 == 0) ? 1 : 0);
            chk("post_rst_ch1", int'(clk_div_out[1]), 0);
        end

        for (int c = 0; c < 4000; c++) begin
            tick();
            ext_rstb = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 19) == 0) ch_en[i] = ~ch_en[i];
            sync_req = ($urandom_range(0, 19) == 0);
            if (!cfg_valid || cfg_ready) begin
                cfg_valid = ($urandom_range(0, 9) < 3);
                cfg_ch = CH_W'($urandom_range(0, NUM_CH - 1));
                r = $urandom_range(0, 39);
                cfg_div = (r < 36) ? DIV_W'(r % 10) : ((r == 39) ? 8'd255 : 8'd2);
            end
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dphy_clkdiv_gen.md
# dphy_clkdiv_gen

Synthesizable, parametrised replacement for the behavioural free-running clock model in the PHY top, which drives `clk_cgra` and the clock/trigger outputs. The block divides one fast reference clock into NUM_CH independently programmable divided clocks, each with a per-period trigger pulse. Divide ratios change glitch-free through a valid/ready configuration port, and all channels can be phase-aligned on request.

## Interface
Parameters:
- NUM_CH, 2, number of divided-clock channels (1..8)
- DIV_W, 8, width of a divide ratio
- DEFAULT_DIV, 2, ratio loaded into every channel at reset (must be at least 2)

Ports:
- clk  input  1  reference clock; all logic on rising edge
- ext_rstb  input  1  asynchronous reset, active low; one clock, reset asynchronous active-low
- ch_en  input  NUM_CH  per-channel run enable
- cfg_valid  input  1  configuration request
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  input  DIV_W  requested ratio
- cfg_ready  output  1  request can be accepted this cycle
- sync_req  input  1  single-cycle request to phase-align all running channels
- clk_div_out  output  NUM_CH  divided clocks (registered)
- trig_out  output  NUM_CH  one-cycle pulse at the start of each period (registered)
- ch_running  output  NUM_CH  channel is actively dividing

## Operation
Per-channel state:
- `active_div[DIV_W]`, `pend_div[DIV_W]`, `pend_flag`, `cnt[DIV_W]`, `running`.

Reset values:
- `active_div` = DEFAULT_DIV; `pend_flag`, `cnt`, `running` = 0.
- `clk_div_out`, `trig_out`, `ch_running` = 0; `cfg_ready` = 1.

Channel FSM:
- States: IDLE, RUN, DRAIN.
- IDLE → RUN when `ch_en`=1 and `active_div`≥2.
  - `cnt` is loaded with 0 on the transition edge.
- RUN:
  - `cnt` increments and wraps from `active_div`−1 to 0.
- RUN → DRAIN when `ch_en`=0.
  - `cnt` keeps counting until the wrap point, then DRAIN → IDLE with `cnt`=0.
  - If `ch_en` returns to 1 during DRAIN, go back to RUN without truncating the period.
- `ch_running` = 1 in RUN and DRAIN.

Outputs:
- Each output flop holds the value for the `cnt` value of the same cycle.
- `clk_div_out` = 1 iff running and `cnt` < floor(`active_div`/2).
  - Odd ratio N: high for (N−1)/2 cycles, low for (N+1)/2 cycles.
- `trig_out` = 1 iff running and `cnt` = 0.
- In IDLE both outputs are 0.

Configuration handshake:
- `cfg_ready` = !`pend_flag`[`cfg_ch`] (combinational on `cfg_ch`).
- A transfer happens when `cfg_valid` and `cfg_ready` are both 1. It stores `pend_div` and sets `pend_flag`.
- `cfg_valid` held while not ready stalls with no side effects. `cfg_ch` ≥ NUM_CH: `cfg_ready`=1 and the request is accepted but discarded.

Ratio application:
- A pending ratio is applied on the edge where `cnt` wraps to 0, or immediately on the next edge if the channel is IDLE. `pend_flag` clears on that same edge.
- The new period begins with `cnt`=0, so no runt pulse is produced.
- An applied ratio of 0 or 1 forces the channel to IDLE after the current period, regardless of `ch_en`. Its outputs then stay 0 until a ratio of 2 or more is applied.

Sync:
- `sync_req`=1 forces `cnt`=0 on the next edge in every channel in RUN.
- A pending ratio is applied on that edge as well.
- The period in progress is truncated; this is the only case that allows a truncated period.
- DRAIN channels ignore sync.

Simultaneous events:
- Sync and wrap on the same edge give the same result as sync.
- A cfg transfer and an apply for the same channel on the same edge are impossible, because `cfg_ready`=0 while pending.
- A cfg transfer into an IDLE channel is applied one edge after acceptance.

Reset mid-operation:
- All state returns to reset values immediately.
- Any pending ratio is lost.

## Timing
- Clocks are generated from flops with zero combinational logic after the flop.
- Latency from `ch_en` sampled high (IDLE) to the first `clk_div_out`=1 and `trig_out`=1: 1 cycle.
- Latency from `ch_en` sampled low to `clk_div_out` held low: the end of the current period, at most `active_div` cycles.
- Worst-case cfg acceptance to effect: `active_div` cycles.
- `cfg_ready` back to 1: the cycle after the apply edge.
- `cnt` is DIV_W bits, compares are unsigned, and ratio 2^DIV_W−1 is the maximum.

## Test plan
- Reset, enable ch0 with DEFAULT_DIV=2 → `clk_div_out`[0] toggles 1,0,1,0…; `trig_out`[0] is high on every high cycle; ch1 stays 0.
- Program ch0 ratio 5 during RUN at `cnt`=1 → old period completes, then repeating pattern 1,1,0,0,0 with `trig_out` on the first 1; `cfg_ready` is 0 until the apply edge.
- Issue a second cfg to ch0 while pending → `cfg_ready`=0, request stalls; after apply it is accepted and applied one period later.
- ch0 ratio 4 and ch1 ratio 6 running, assert `sync_req` → both `cnt`=0 on the next edge and `trig_out`=2'b11 in the same cycle.
- Deassert `ch_en`[0] at `cnt`=1 with ratio 4 → cycles `cnt`=2 and 3 complete, then IDLE with outputs 0; re-enable during DRAIN → no gap in the pattern.
- Apply ratio 1 to ch1, then ratio 3; also assert `ext_rstb` low mid-period → ch1 goes IDLE with outputs 0 until ratio 3 is applied; reset clears all outputs asynchronously and restores ratio 2.
